// File: rtl/nes_snes_poll_sequencer.sv
// Bus-mapped NES/SNES controller poll scheduler: drives the shared latch/clock pair,
// shifts in both pads in parallel and commits each frame atomically to readable registers.
module nes_snes_poll_sequencer #(
    parameter int unsigned HALF_CYCLES = 384,
    parameter int unsigned TICK_BITS   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       frame_irq
);

    localparam int unsigned CNT_W = $clog2(2 * HALF_CYCLES);
    localparam int unsigned BIT_W = 4;
    localparam int unsigned BTN_W = 16;
    localparam int unsigned REG_W = 8;

    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_PERIOD = 4'h1;
    localparam logic [3:0] A_STATUS = 4'h2;
    localparam logic [3:0] A_P0_LO  = 4'h4;
    localparam logic [3:0] A_P0_HI  = 4'h5;
    localparam logic [3:0] A_P1_LO  = 4'h6;
    localparam logic [3:0] A_P1_HI  = 4'h7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               len16_q, len16_d;
    logic [BTN_W-1:0]   sr0_q, sr0_d, sr1_q, sr1_d;
    logic               latch_q, latch_d, pclk_q, pclk_d;
    logic               commit_c;
    logic [BIT_W-1:0]   last_bit_c;

    logic [BTN_W-1:0]   btn0_q, btn1_q;
    logic               snes_q, auto_q;
    logic [REG_W-1:0]   period_q;
    logic               new_q, ovr_q, pend_q;
    logic [TICK_BITS-1:0] tick_q;
    logic [REG_W-1:0]   ival_q;

    logic               wr_ctrl_c, wr_period_c, wr_status_c;
    logic               sw_start_c, auto_start_c, tick_wrap_c, busy_c;
    logic [REG_W-1:0]   period_eff_c, wr_period_eff_c;

    assign wr_ctrl_c       = data_write && (address == A_CTRL);
    assign wr_period_c     = data_write && (address == A_PERIOD);
    assign wr_status_c     = data_write && (address == A_STATUS);
    assign sw_start_c      = wr_ctrl_c && data_in[7];
    assign tick_wrap_c     = (tick_q == '1);
    assign auto_start_c    = auto_q && tick_wrap_c && (ival_q == REG_W'(1));
    assign period_eff_c    = (period_q == '0) ? REG_W'(1) : period_q;
    assign wr_period_eff_c = (data_in == '0) ? REG_W'(1) : data_in;
    assign busy_c          = (state_q != ST_IDLE);
    assign last_bit_c      = len16_q ? BIT_W'(15) : BIT_W'(7);

    // Waveform sequencer: next state, phase counter and shift-in of both pads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        len16_d  = len16_q;
        sr0_d    = sr0_q;
        sr1_d    = sr1_q;
        commit_c = 1'b0;
        latch_d  = 1'b0;
        pclk_d   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pend_q) begin
                    state_d = ST_LATCH;
                    bit_d   = '0;
                    len16_d = snes_q;
                    sr0_d   = '0;
                    sr1_d   = '0;
                end
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    sr0_d[bit_q] = ~pad_data[0];
                    sr1_d[bit_q] = ~pad_data[1];
                    bit_d        = bit_q + BIT_W'(1);
                    cnt_d        = '0;
                    state_d      = ST_CLK_LO;
                end
            end
            ST_CLK_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                if (cnt_q == HALF_LAST) begin
                    sr0_d[bit_q] = ~pad_data[0];
                    sr1_d[bit_q] = ~pad_data[1];
                    bit_d        = bit_q + BIT_W'(1);
                    cnt_d        = '0;
                    state_d      = (bit_q == last_bit_c) ? ST_COMMIT : ST_CLK_LO;
                end
            end
            ST_COMMIT: begin
                commit_c = 1'b1;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        latch_d = (state_d == ST_LATCH);
        pclk_d  = (state_d != ST_CLK_LO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            len16_q <= 1'b0;
            sr0_q   <= '0;
            sr1_q   <= '0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            len16_q <= len16_d;
            sr0_q   <= sr0_d;
            sr1_q   <= sr1_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
        end
    end

    // Register bank, pending-start flag, status flags and auto-poll timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snes_q   <= 1'b0;
            auto_q   <= 1'b1;
            period_q <= REG_W'(8'h10);
            new_q    <= 1'b0;
            ovr_q    <= 1'b0;
            pend_q   <= 1'b0;
            tick_q   <= '0;
            ival_q   <= REG_W'(8'h10);
            btn0_q   <= '0;
            btn1_q   <= '0;
        end else begin
            if (wr_ctrl_c) begin
                snes_q <= data_in[0];
                auto_q <= data_in[1];
            end
            if (wr_period_c) begin
                period_q <= data_in;
            end

            pend_q <= (pend_q && busy_c) || sw_start_c || auto_start_c;

            // A commit outranks a same-cycle status clear.
            if (commit_c) begin
                btn0_q <= sr0_q;
                btn1_q <= sr1_q;
                new_q  <= 1'b1;
                if (new_q) begin
                    ovr_q <= 1'b1;
                end else if (wr_status_c) begin
                    ovr_q <= 1'b0;
                end
            end else if (wr_status_c) begin
                new_q <= 1'b0;
                ovr_q <= 1'b0;
            end

            if (!auto_q) begin
                tick_q <= '0;
                ival_q <= period_eff_c;
            end else begin
                tick_q <= tick_q + TICK_BITS'(1);
                if (tick_wrap_c) begin
                    ival_q <= (ival_q == REG_W'(1)) ? period_eff_c : ival_q - REG_W'(1);
                end
            end
            if (wr_period_c) begin
                ival_q <= wr_period_eff_c;
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            A_CTRL:   data_out = {6'b0, auto_q, snes_q};
            A_PERIOD: data_out = period_q;
            A_STATUS: data_out = {5'b0, ovr_q, new_q, busy_c};
            A_P0_LO:  data_out = btn0_q[7:0];
            A_P0_HI:  data_out = btn0_q[15:8];
            A_P1_LO:  data_out = btn1_q[7:0];
            A_P1_HI:  data_out = btn1_q[15:8];
            default:  data_out = '0;
        endcase
    end

    assign pad_latch = latch_q;
    assign pad_clk   = pclk_q;
    assign frame_irq = new_q;

endmodule

// File: tb/tb_nes_snes_poll_sequencer.sv
// Bench for nes_snes_poll_sequencer: register table, directed frame sequences and
// randomized bus/pad traffic checked against a frame-offset reference model.
module tb_nes_snes_poll_sequencer;

    localparam int H  = 4;
    localparam int TB = 4;
    localparam int PH = 2 * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pad_data = 2'b11;
    logic [3:0] address = 4'h2;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       pad_latch, pad_clk, frame_irq;
    logic [7:0] data_out;

    nes_snes_poll_sequencer #(.HALF_CYCLES(H), .TICK_BITS(TB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .frame_irq  (frame_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Reference model: a frame is an offset counted from the first latch-high cycle.
    bit          m_busy, m_pend, m_new, m_ovr, m_snes, m_auto;
    int          m_off, m_len;
    logic [15:0] m_sr0, m_sr1, m_b0, m_b1;
    logic [7:0]  m_period;

    bit          chk_en = 1'b1;
    bit          use_stream = 1'b0;
    logic [15:0] s0 = 16'hFFFF;
    logic [15:0] s1 = 16'hFFFF;
    int          rises[$];
    int          falls[$];
    int          irqs[$];
    int          lat_hi = 0;
    int          clk_falls = 0;
    bit          prev_latch = 1'b0, prev_busy = 1'b0, prev_irq = 1'b0, prev_pclk = 1'b1;

    typedef struct {
        bit         wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[17];

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, n);
        end
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -100000;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_pend = 0; m_new = 0; m_ovr = 0; m_snes = 0; m_auto = 1;
        m_off = 0; m_len = 8; m_sr0 = '0; m_sr1 = '0; m_b0 = '0; m_b1 = '0;
        m_period = 8'h10;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        case (a)
            4'h0:    return {6'b0, m_auto, m_snes};
            4'h1:    return m_period;
            4'h2:    return {5'b0, m_ovr, m_new, m_busy};
            4'h4:    return m_b0[7:0];
            4'h5:    return m_b0[15:8];
            4'h6:    return m_b1[7:0];
            4'h7:    return m_b1[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit m_latch();
        return m_busy && (m_off < PH);
    endfunction

    function automatic bit m_pclk();
        return !(m_busy && m_off >= PH && m_off < PH * m_len && ((m_off - PH) % PH) < H);
    endfunction

    // Advance the model across one clock edge using the inputs held during that cycle.
    function automatic void model_step();
        bit start, clr, commit;
        int k;
        start  = data_write && (address == 4'h0) && data_in[7];
        clr    = data_write && (address == 4'h2);
        commit = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            if (m_off < PH * m_len) begin
                if ((m_off + 1) % PH == 0) begin
                    k = (m_off + 1) / PH - 1;
                    m_sr0[k] = ~pad_data[0];
                    m_sr1[k] = ~pad_data[1];
                end
                m_off++;
            end else begin
                commit = 1;
                m_busy = 0;
            end
            m_pend = m_pend || start;
        end else begin
            if (m_pend) begin
                m_busy = 1; m_off = 0; m_len = m_snes ? 16 : 8;
                m_sr0 = '0; m_sr1 = '0;
            end
            m_pend = start;
        end
        if (commit) begin
            if (m_new) m_ovr = 1;
            else if (clr) m_ovr = 0;
            m_new = 1; m_b0 = m_sr0; m_b1 = m_sr1;
        end else if (clr) begin
            m_new = 0; m_ovr = 0;
        end
        if (data_write && address == 4'h0) begin
            m_snes = data_in[0];
            m_auto = data_in[1];
        end
        if (data_write && address == 4'h1) m_period = data_in;
    endfunction

    task automatic step_chk();
        logic [3:0] a_save;
        logic [7:0] st;
        int k;
        if (use_stream) begin
            k = m_busy ? m_off / PH : 0;
            if (k > 15) k = 15;
            pad_data = {s1[k], s0[k]};
        end else begin
            pad_data = 2'($urandom);
        end
        @(posedge clk);
        model_step();
        n++;
        #1;
        a_save  = address;
        address = 4'h2;
        #1;
        st = data_out;
        if (chk_en) begin
            chk("latch", int'(pad_latch), int'(m_latch()));
            chk("pad_clk", int'(pad_clk), int'(m_pclk()));
            chk("irq", int'(frame_irq), int'(m_new));
            chk("status", int'(st), int'(m_read(4'h2)));
            for (int j = 0; j < 8; j++) begin
                if (j != 2 && j != 3) begin
                    address = 4'(j);
                    #1;
                    chk($sformatf("rd%0h", j), int'(data_out), int'(m_read(4'(j))));
                end
            end
        end
        address = a_save;
        if (pad_latch && !prev_latch) rises.push_back(n);
        if (!st[0] && prev_busy) falls.push_back(n);
        if (frame_irq && !prev_irq) irqs.push_back(n);
        if (!pad_clk && prev_pclk) clk_falls++;
        if (pad_latch) lat_hi++;
        prev_latch = pad_latch;
        prev_busy  = st[0];
        prev_irq   = frame_irq;
        prev_pclk  = pad_clk;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a; data_in = d; data_write = 1'b1;
        step_chk();
        data_write = 1'b0; address = 4'h2;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [7:0] exp);
        step_chk();
        address = a;
        #1;
        chk(nm, int'(data_out), int'(exp));
        address = 4'h2;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step_chk();
    endtask

    task automatic wait_falls(input int cnt, input int budget, input string nm);
        int i;
        i = 0;
        while (falls.size() < cnt && i < budget) begin
            step_chk();
            i++;
        end
        if (falls.size() < cnt) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic clear_events();
        rises.delete(); falls.delete(); irqs.delete();
        lat_hi = 0; clk_falls = 0;
    endtask

    initial begin
        int wcyc, r, i;
        model_reset();

        // Reset state.
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;

        vt[0]  = '{0, 4'h0, 8'h00, 8'h02};
        vt[1]  = '{0, 4'h1, 8'h00, 8'h10};
        vt[2]  = '{0, 4'h2, 8'h00, 8'h00};
        vt[3]  = '{0, 4'h3, 8'h00, 8'h00};
        vt[4]  = '{0, 4'h4, 8'h00, 8'h00};
        vt[5]  = '{0, 4'h5, 8'h00, 8'h00};
        vt[6]  = '{0, 4'h6, 8'h00, 8'h00};
        vt[7]  = '{0, 4'h7, 8'h00, 8'h00};
        vt[8]  = '{1, 4'h0, 8'h00, 8'h00};
        vt[9]  = '{1, 4'h1, 8'h5A, 8'h5A};
        vt[10] = '{1, 4'h3, 8'hFF, 8'h00};
        vt[11] = '{1, 4'h0, 8'h01, 8'h01};
        vt[12] = '{1, 4'h0, 8'h00, 8'h00};
        vt[13] = '{1, 4'h1, 8'h00, 8'h00};
        vt[14] = '{1, 4'h1, 8'h10, 8'h10};
        vt[15] = '{1, 4'h2, 8'hFF, 8'h00};
        vt[16] = '{0, 4'hF, 8'h00, 8'h00};
        for (int v = 0; v < 17; v++) begin
            if (vt[v].wr) wr(vt[v].a, vt[v].d);
            else step_chk();
            address = vt[v].a;
            #1;
            chk($sformatf("vec%0d", v), int'(data_out), int'(vt[v].exp));
            address = 4'h2;
        end

        // NES frame on port 0.
        use_stream = 1'b1;
        s0 = 16'hFF7E; s1 = 16'hFFFF;
        run(2);
        clear_events();
        wcyc = n;
        wr(4'h0, 8'h80);
        wait_falls(1, 200, "nes");
        chk("nes_latency", qat(rises, 0) - wcyc, 2);
        chk("nes_latch_w", lat_hi, PH);
        chk("nes_pulses", clk_falls, 7);
        chk("nes_irq", qat(irqs, 0) - qat(rises, 0), PH * 8 + 1);
        chk("nes_len", qat(falls, 0) - qat(rises, 0), PH * 8 + 1);
        rd_chk("nes_p0lo", 4'h4, 8'h81);
        rd_chk("nes_p0hi", 4'h5, 8'h00);
        rd_chk("nes_p1lo", 4'h6, 8'h00);
        rd_chk("nes_st", 4'h2, 8'h02);

        // SNES frame on port 1, then overrun and status clear.
        s0 = 16'hFFFF; s1 = 16'h5AA5;
        clear_events();
        wr(4'h0, 8'h81);
        wait_falls(1, 300, "snes");
        chk("snes_len", qat(falls, 0) - qat(rises, 0), PH * 16 + 1);
        rd_chk("snes_p1lo", 4'h6, 8'h5A);
        rd_chk("snes_p1hi", 4'h7, 8'hA5);
        rd_chk("snes_p0lo", 4'h4, 8'h00);
        rd_chk("snes_p0hi", 4'h5, 8'h00);
        rd_chk("snes_ovr", 4'h2, 8'h06);
        wr(4'h2, 8'h00);
        address = 4'h2;
        #1;
        chk("st_clear", int'(data_out), 0);
        wr(4'h0, 8'h00);

        // Starts while busy and while pending merge into one extra frame.
        s0 = 16'h3C0F; s1 = 16'h00FF;
        clear_events();
        wr(4'h0, 8'h80);
        run(20);
        wr(4'h0, 8'h80);
        run(3);
        wr(4'h0, 8'h80);
        run(260);
        chk("merge_frames", rises.size(), 2);
        chk("merge_gap", qat(rises, 1) - qat(rises, 0), PH * 8 + 2);
        rd_chk("merge_st", 4'h2, 8'h06);
        wr(4'h2, 8'h00);

        // Randomized bus traffic and pad data.
        use_stream = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 3) wr(4'h0, ($urandom_range(0, 3) != 0 ? 8'h80 : 8'h00) | 8'($urandom_range(0, 1)));
            else if (r < 4) wr(4'h2, 8'($urandom));
            else if (r < 5) wr(4'h1, 8'($urandom));
            else if (r < 6) wr(4'($urandom_range(3, 15)), 8'($urandom));
            else step_chk();
        end
        wr(4'h0, 8'h00);
        run(300);

        // Auto-poll cadence, then disable.
        chk_en = 1'b0;
        wr(4'h1, 8'h06);
        clear_events();
        wcyc = n;
        wr(4'h0, 8'h02);
        i = 0;
        while (rises.size() < 2 && i < 400) begin
            step_chk();
            i++;
        end
        chk("auto_first", qat(rises, 0) - wcyc, 2 + 16 * 6);
        chk("auto_period", qat(rises, 1) - qat(rises, 0), 16 * 6);
        wr(4'h0, 8'h00);
        clear_events();
        run(300);
        chk("auto_stop", rises.size(), 0);

        // Reset in the middle of a low clock phase.
        wr(4'h0, 8'h80);
        i = 0;
        while (pad_clk && i < 100) begin
            step_chk();
            i++;
        end
        chk("clk_lo_seen", int'(pad_clk), 0);
        rst_n = 1'b0;
        step_chk();
        chk("rst_pclk", int'(pad_clk), 1);
        chk("rst_latch", int'(pad_latch), 0);
        chk("rst_irq", int'(frame_irq), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        run(20);
        rd_chk("rst_ctrl", 4'h0, 8'h02);
        rd_chk("rst_period", 4'h1, 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nes_snes_poll_sequencer.md
# nes_snes_poll_sequencer

Bus-mapped poll scheduler for NES/SNES game controllers on the TinyQV peripheral bus. It generates the latch and clock waveform for two controller ports that share one latch line and one clock line, and shifts in both ports' data lines in parallel. It commits each completed frame atomically into readable registers and flags new data. Polls are started by software or by a programmable auto-poll timer, so the CPU never bit-bangs the pads.

## Interface
Parameters:
- HALF_CYCLES, 384: clk cycles per clock half-period (6 µs at 64 MHz). Latch width is 2*HALF_CYCLES.
- TICK_BITS, 16: auto-poll tick is 2^TICK_BITS clk cycles (1.024 ms at 64 MHz).

Ports:
- clk  in  1  system clock (64 MHz)
- rst_n  in  1  synchronous, active-low reset
- pad_data  in  2  serial data from port 0 and port 1. Already 2-FF synchronized. Pad drives 0 for a pressed button.
- pad_latch  out  1  shared latch, active high
- pad_clk  out  1  shared clock, idles high
- address  in  4  register address
- data_write  in  1  write strobe, one cycle
- data_in  in  8  write data
- data_out  out  8  combinational read data for address
- frame_irq  out  1  level interrupt; equals STATUS.new_data

## Operation
Register map (unlisted addresses read 0, writes ignored):
- 0x0 CTRL (RW, reset 0x02)
  - bit0 snes_mode: 0 = 8 bits per port, 1 = 16 bits per port.
  - bit1 auto_en.
  - bit7 is write-1-to-start and self-clearing; it always reads 0.
- 0x1 PERIOD (RW, reset 0x10): auto-poll interval in ticks. A value of 0 behaves as 1.
- 0x2 STATUS (R)
  - bit0 busy; bit1 new_data; bit2 overrun.
  - Any write to 0x2 clears new_data and overrun.
- 0x4/0x5 port 0 buttons, low/high byte. 0x6/0x7 port 1 buttons, low/high byte.
  - Stored active-high: stored bit = ~pad_data.
  - Bit i holds the i-th sampled bit. Bit 0 is sampled first (A on NES, B on SNES).
  - The high byte reads 0 after an NES-mode frame.

FSM states: IDLE, LATCH, CLK_LO, CLK_HI, COMMIT.
- IDLE: pad_latch=0, pad_clk=1. A pending start moves to LATCH. At that transition, snes_mode is captured into frame_len (8 or 16) and the bit counter is cleared.
- LATCH: pad_latch=1 for 2*HALF_CYCLES cycles. On its last cycle, sample bit 0 of both ports, then go to CLK_LO.
- CLK_LO: pad_clk=0 for HALF_CYCLES cycles, then go to CLK_HI.
- CLK_HI: pad_clk=1 for HALF_CYCLES cycles. On its last cycle, sample the next bit. Then go to CLK_LO if frame_len bits have not been taken, otherwise go to COMMIT.
- COMMIT (1 cycle):
  - Copy both shift registers into the button registers together.
  - If new_data was already set, set overrun.
  - Set new_data, then go to IDLE.
- busy = (state != IDLE).

Start sources:
- A CTRL bit7 write.
- Auto-poll: while auto_en=1, a free-running tick counter and an interval counter raise a start every PERIOD ticks.
  - Clearing auto_en resets both counters.
  - Writing PERIOD reloads the interval counter.

Boundary rules:
- One pending-start flag only. Starts arriving while busy or already pending merge into that flag, and the deferred poll begins on the first IDLE cycle.
- A simultaneous software and auto start produce one frame.
- A snes_mode change mid-frame takes effect on the next frame.
- Button registers change only in COMMIT. They are never partially updated.
- If a STATUS clear write and COMMIT fall in the same cycle, COMMIT wins: new_data=1.

## Timing
- Reset values: pad_latch=0, pad_clk=1, frame_irq=0. All registers at their reset values, buttons 0, state IDLE, pending 0.
- A reset asserted mid-frame returns the outputs to idle levels on the next clk edge.
- Start-to-latch latency: a start write in cycle t gives pad_latch=1 from cycle t+2. That is one cycle to set pending plus one for the IDLE→LATCH transition.
- Frame length, rising pad_latch to COMMIT: 2*HALF_CYCLES*frame_len cycles.
- new_data and frame_irq rise one cycle after COMMIT.
- Write-side effects are visible on data_out the cycle after data_write.

## Test plan
- Reset, then idle: pad_latch=0, pad_clk=1, CTRL reads 0x02, PERIOD reads 0x10, STATUS reads 0, all button bytes read 0.
- HALF_CYCLES=4, auto_en=0, NES mode, write CTRL=0x80.
  - pad_data[0] serial stream 0,1,1,1,1,1,1,0 → 0x4 reads 0x81 and 0x5 reads 0x00.
  - pad_latch is high for exactly 8 cycles; 7 low clock pulses of 4 cycles each.
  - COMMIT 64 cycles after latch rise; frame_irq=1.
- SNES mode, 16-bit stream on port 1 = inverse of 0xA55A → 0x6 reads 0x5A and 0x7 reads 0xA5. Port 0 held 1 → 0x4 and 0x5 read 0x00.
- Start written while busy, plus a start while pending → exactly one extra frame immediately after the current one.
- Second frame completes without a STATUS clear → STATUS reads 0x06. Writing 0x2 → STATUS reads 0x00.
- TICK_BITS=4, PERIOD=2, auto_en=1 → a latch rise every 32 cycles. Clearing auto_en stops further frames. Reset asserted mid-CLK_LO → pad_clk=1 and pad_latch=0 on the next edge.
